mist1032isa_uart_rx_frame: RTL

Parametrised UART receive framer with a configurable oversampling factor, data width, parity and stop bits, and a show-ahead receive FIFO that carries per-word error flags. It runs entirely in the oversample-tick domain: the baudrate generator drives its clock, and the host-side clock-domain crossing stage consumes its output. It adds start-glitch rejection, parity/framing/break detection and sticky overrun reporting. The earlier fixed 8N1 receiver has none of these.

---
 rtl/mist1032isa_uart_rx_pkg.sv | 34 +++
 rtl/mist1032isa_uart_rx_fifo.sv | 51 +++++
 rtl/mist1032isa_uart_rx_frame.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mist1032isa_uart_rx_pkg.sv
// Purpose: shared types and constants for the UART receive framer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mist1032isa_uart_rx_pkg;

    // Widest supported data field; narrower builds zero-extend into it.
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef struct packed {
        logic                     brk;
        logic                     ferr;
        logic                     perr;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_word_t;

    // Mode 11 is deliberately treated like "none".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/mist1032isa_uart_rx_fifo.sv
// Purpose: generic show-ahead single-clock FIFO; head is visible whenever not empty.
// Latency: a push is visible at the head one edge after it is written.
// Backpressure: push is refused when full unless a pop happens on the same edge.
module mist1032isa_uart_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         b_bd_clock,
    input  logic         inRESET,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop_rdy && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge b_bd_clock or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mist1032isa_uart_rx_frame.sv
// Purpose: oversampled UART receive framer with parity/framing/break flags; MIST1032ISA_UART_RX_MAJORITY_EN enables 3-sample majority voting.
// Latency: word is pushed one edge after the final stop sample and is at the FIFO head on the edge after that.
// Backpressure: none toward the line; a frame arriving at a full FIFO with no pop is dropped and oOVERRUN is set.
module mist1032isa_uart_rx_frame
    import mist1032isa_uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 4,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 b_bd_clock,
    input  logic                 inRESET,
    input  logic                 iUART_RXD,
    input  logic [1:0]           iPARITY_MODE,
    input  logic                 iSTOP2,
    output logic                 oRX_VALID,
    input  logic                 iRX_READY,
    output logic [DATA_BITS-1:0] oRX_DATA,
    output logic                 oRX_PERR,
    output logic                 oRX_FERR,
    output logic                 oRX_BREAK,
    output logic                 oOVERRUN,
    input  logic                 iOVR_CLR,
    output logic                 oBUSY
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rxd_m;
    logic                 rxd_s;
    logic                 smp;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           par_mode_q;
    logic                 stop2_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 zero_q;
    logic                 cnt_hit;
    logic                 smp_en;
    logic                 last_stop;
    logic                 push_vld;
    rx_word_t             push_word;
    rx_word_t             head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;
    logic                 ovr;
    logic                 unused_head;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge b_bd_clock or negedge inRESET) begin
        if (!inRESET) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= iUART_RXD;
            rxd_s <= rxd_m;
        end
    end

`ifdef MIST1032ISA_UART_RX_MAJORITY_EN
    logic rxd_h1;
    logic rxd_h2;

    // History of the synchronised line for the majority vote.
    always_ff @(posedge b_bd_clock or negedge inRESET) begin
        if (!inRESET) begin
            rxd_h1 <= 1'b1;
            rxd_h2 <= 1'b1;
        end else begin
            rxd_h1 <= rxd_s;
            rxd_h2 <= rxd_h1;
        end
    end

    assign smp = (rxd_s & rxd_h1) | (rxd_s & rxd_h2) | (rxd_h1 & rxd_h2);
`else
    assign smp = rxd_s;
`endif

    // Start sample sits half a bit in; every later sample is one full bit later.
    assign cnt_hit = (state == ST_START) ? (cnt == CNT_HALF) : (cnt == CNT_FULL);

    // FSM state register.
    always_ff @(posedge b_bd_clock or negedge inRESET) begin
        if (!inRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus sample and end-of-frame strobes.
    always_comb begin
        state_nxt = state;
        smp_en    = 1'b0;
        last_stop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxd_s) state_nxt = ST_START;
            end
            ST_START: begin
                if (cnt_hit) begin
                    smp_en    = 1'b1;
                    state_nxt = smp ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_hit) begin
                    smp_en = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt = parity_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_hit) begin
                    smp_en    = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_hit) begin
                    smp_en = 1'b1;
                    if (!stop2_q || stop_idx) begin
                        last_stop = 1'b1;
                        state_nxt = smp ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxd_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bit timing, data shift, error accumulation and the registered push strobe.
    always_ff @(posedge b_bd_clock or negedge inRESET) begin
        if (!inRESET) begin
            cnt        <= '0;
            idx        <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_mode_q <= PAR_NONE;
            stop2_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b1;
            push_vld   <= 1'b0;
            push_word  <= '0;
        end else begin
            push_vld <= 1'b0;
            if (state == ST_IDLE) begin
                // Mode is captured continuously while idle, so the value at start detection sticks.
                cnt        <= '0;
                idx        <= '0;
                stop_idx   <= 1'b0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
                zero_q     <= 1'b1;
                par_mode_q <= iPARITY_MODE;
                stop2_q    <= iSTOP2;
            end else if (smp_en) begin
                cnt <= '0;
                case (state)
                    ST_DATA: begin
                        shreg  <= {smp, shreg[DATA_BITS-1:1]};
                        idx    <= idx + IW'(1);
                        zero_q <= zero_q & ~smp;
                    end
                    ST_PARITY: begin
                        perr_q <= (^shreg) ^ smp ^ (par_mode_q == PAR_ODD);
                        zero_q <= zero_q & ~smp;
                    end
                    ST_STOP: begin
                        ferr_q   <= ferr_q | ~smp;
                        zero_q   <= zero_q & ~smp;
                        stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (last_stop) begin
                push_vld       <= 1'b1;
                push_word.brk  <= zero_q & ~smp;
                push_word.ferr <= ferr_q | ~smp;
                push_word.perr <= perr_q;
                push_word.data <= MAX_DATA_BITS'(shreg);
            end
        end
    end

    mist1032isa_uart_rx_fifo #(
        .W     ($bits(rx_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .b_bd_clock (b_bd_clock),
        .inRESET    (inRESET),
        .push_vld   (push_vld),
        .push_dat   (push_word),
        .pop_rdy    (iRX_READY),
        .head_dat   (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign drop = push_vld && fifo_full && !iRX_READY;

    // Sticky overrun; a drop on the clear edge keeps it set.
    always_ff @(posedge b_bd_clock or negedge inRESET) begin
        if (!inRESET) begin
            ovr <= 1'b0;
        end else if (drop) begin
            ovr <= 1'b1;
        end else if (iOVR_CLR) begin
            ovr <= 1'b0;
        end
    end

    assign oRX_VALID   = !fifo_empty;
    assign oRX_DATA    = head.data[DATA_BITS-1:0];
    assign oRX_PERR    = head.perr;
    assign oRX_FERR    = head.ferr;
    assign oRX_BREAK   = head.brk;
    assign oOVERRUN    = ovr;
    assign oBUSY       = (state != ST_IDLE);
    assign unused_head = ^(head.data >> DATA_BITS);

endmodule
